// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, output sample type and log2 helper for the FIR output stage.
package fir_pkg;
  localparam int FIR_IN_W = 10;
  localparam int FIR_OUT_W = 8;
  typedef logic [FIR_OUT_W-1:0] fir_sample_t;
  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: 2-entry in-order FIFO with synchronous clear; head reads 0 when empty.
module fir_out_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  logic [W-1:0] m0_q, m0_d, m1_q, m1_d;
  logic [1:0] cnt_q, cnt_d;
  logic pp, pu;
  always_comb begin
    pp = pop && cnt_q != 2'd0;
    pu = push && (cnt_q != 2'd2 || pp);
    m0_d = m0_q;
    m1_d = m1_q;
    cnt_d = cnt_q;
    if (clr) begin
      m0_d = '0;
      m1_d = '0;
      cnt_d = 2'd0;
    end else if (pu && pp) begin
      m0_d = (cnt_q == 2'd2) ? m1_q : din;
      m1_d = (cnt_q == 2'd2) ? din : m1_q;
    end else if (pp) begin
      m0_d = m1_q;
      cnt_d = cnt_q - 2'd1;
    end else if (pu) begin
      m0_d = (cnt_q == 2'd0) ? din : m0_q;
      m1_d = (cnt_q == 2'd1) ? din : m1_q;
      cnt_d = cnt_q + 2'd1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_q <= '0;
      m1_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      m0_q <= m0_d;
      m1_q <= m1_d;
      cnt_q <= cnt_d;
    end
  end
  assign full = cnt_q == 2'd2;
  assign empty = cnt_q == 2'd0;
  assign head = empty ? '0 : m0_q;
endmodule

// File: rtl/fir_decim_out.sv
// fir_decim_out: accumulate-and-dump decimator with round/saturate into a 2-entry output buffer.
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int IN_W = FIR_IN_W,
  parameter int OUT_W = FIR_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  din,
  input  logic             sync_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic             sat,
  output logic             ovf
);
  localparam int LG = log2c(DECIM);
  localparam int AW = IN_W + LG;
  logic [AW-1:0] acc_q, acc_d;
  logic [LG-1:0] ph_q, ph_d;
  logic sat_q, sat_d, ovf_q, ovf_d;
  logic acc_en, dump, clip, push, pop, full, empty;
  logic [AW:0] sum, avg;
  logic [OUT_W-1:0] res;
  // One spare bit keeps the rounding add from wrapping for any legal DECIM.
  always_comb begin
    acc_en = in_valid && !sync_clr;
    dump = acc_en && ph_q == LG'(DECIM - 1);
    sum = {1'b0, acc_q} + (AW + 1)'(din);
    avg = (sum + (AW + 1)'(DECIM / 2)) >> LG;
    clip = avg > (AW + 1)'((1 << OUT_W) - 1);
    res = clip ? '1 : avg[OUT_W-1:0];
    pop = !empty && out_ready && !sync_clr;
    push = dump;
    acc_d = (sync_clr || dump) ? '0 : acc_en ? sum[AW-1:0] : acc_q;
    ph_d = (sync_clr || dump) ? '0 : acc_en ? ph_q + LG'(1) : ph_q;
    sat_d = !sync_clr && (sat_q || (dump && clip));
    ovf_d = !sync_clr && (ovf_q || (dump && full && !pop));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      ph_q <= '0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ph_q <= ph_d;
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  end
  fir_out_fifo #(.W(OUT_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(sync_clr),
    .push(push),
    .pop(pop),
    .din(res),
    .full(full),
    .empty(empty),
    .head(dout)
  );
  assign out_valid = !empty;
  assign sat = sat_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_fir_decim_out.sv
// tb_fir_decim_out: directed checks of averaging, rounding, saturation, buffering, clears and reset.
module tb_fir_decim_out;
  logic clk, rst, in_valid, sync_clr, out_ready, out_valid, sat, ovf;
  logic [9:0] din;
  logic [7:0] dout;
  int checks, failures;

  fir_decim_out #(.DECIM(4), .IN_W(10), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .sync_clr(sync_clr),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .sat(sat), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [9:0] d);
    in_valid = 1'b1;
    din = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input logic [9:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    sync_clr = 1'b1;
    idle();
    sync_clr = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (dout !== 8'd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", dout); end
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b exp=0", sat); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
  endtask

  task automatic test_average();
    out_ready = 1'b0;
    send(100); send(101); send(102);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL avg_early_valid got=%0b exp=0", out_valid); end
    send(103);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL avg_valid got=%0b exp=1", out_valid); end
    checks++; if (dout !== 8'd102) begin failures++; $display("FAIL avg_dout got=%0d exp=102", dout); end
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL avg_sat got=%0b exp=0", sat); end
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL avg_pop_valid got=%0b exp=0", out_valid); end
    checks++; if (dout !== 8'd0) begin failures++; $display("FAIL avg_empty_dout got=%0d exp=0", dout); end
  endtask

  task automatic test_rounding();
    out_ready = 1'b0;
    send4(1, 1, 1, 3);
    checks++; if (dout !== 8'd2) begin failures++; $display("FAIL round_half_up got=%0d exp=2", dout); end
    clear();
    send4(1, 1, 1, 2);
    checks++; if (dout !== 8'd1) begin failures++; $display("FAIL round_down got=%0d exp=1", dout); end
    clear();
  endtask

  task automatic test_saturate();
    out_ready = 1'b0;
    send4(1023, 1023, 1023, 1023);
    checks++; if (dout !== 8'd255) begin failures++; $display("FAIL sat_dout got=%0d exp=255", dout); end
    checks++; if (sat !== 1'b1) begin failures++; $display("FAIL sat_flag got=%0b exp=1", sat); end
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    send4(8, 8, 8, 8);
    checks++; if (dout !== 8'd8) begin failures++; $display("FAIL sat_next_dout got=%0d exp=8", dout); end
    checks++; if (sat !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%0b exp=1", sat); end
    clear();
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL sat_clr got=%0b exp=0", sat); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    send4(4, 4, 4, 4);
    send4(40, 40, 40, 40);
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0b exp=0", ovf); end
    send4(80, 80, 80, 80);
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", ovf); end
    checks++; if (dout !== 8'd4) begin failures++; $display("FAIL ovf_head got=%0d exp=4", dout); end
    out_ready = 1'b1;
    idle();
    checks++; if (dout !== 8'd40 || out_valid !== 1'b1) begin failures++; $display("FAIL ovf_second got=%0d/%0b exp=40/1", dout, out_valid); end
    idle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%0b exp=0", out_valid); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", ovf); end
    clear();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send4(10, 10, 10, 10);
    send4(20, 20, 20, 20);
    send(30); send(30); send(30);
    out_ready = 1'b1;
    send(30);
    out_ready = 1'b0;
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%0b exp=0", ovf); end
    checks++; if (dout !== 8'd20) begin failures++; $display("FAIL b2b_head got=%0d exp=20", dout); end
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    checks++; if (dout !== 8'd30) begin failures++; $display("FAIL b2b_tail got=%0d exp=30", dout); end
    send(50); send(50); send(50);
    out_ready = 1'b1;
    send(50);
    out_ready = 1'b0;
    checks++; if (dout !== 8'd50 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_occ1 got=%0d/%0b exp=50/1", dout, out_valid); end
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_sync_clr();
    out_ready = 1'b0;
    send4(1023, 1023, 1023, 1023);
    send(200); send(200);
    in_valid = 1'b1;
    din = 10'd999;
    sync_clr = 1'b1;
    out_ready = 1'b1;
    idle();
    in_valid = 1'b0;
    sync_clr = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || dout !== 8'd0) begin failures++; $display("FAIL clr_buffer got=%0b/%0d exp=0/0", out_valid, dout); end
    checks++; if (sat !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL clr_flags got=%0b/%0b exp=0/0", sat, ovf); end
    send(8); send(8); send(8);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_phase got=%0b exp=0", out_valid); end
    send(8);
    checks++; if (dout !== 8'd8 || out_valid !== 1'b1) begin failures++; $display("FAIL clr_next got=%0d/%0b exp=8/1", dout, out_valid); end
    clear();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send4(1023, 1023, 1023, 1023);
    send4(1023, 1023, 1023, 1023);
    send4(1023, 1023, 1023, 1023);
    send(500); send(500);
    #3;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || dout !== 8'd0) begin failures++; $display("FAIL arst_buffer got=%0b/%0d exp=0/0", out_valid, dout); end
    checks++; if (sat !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL arst_flags got=%0b/%0b exp=0/0", sat, ovf); end
    idle();
    rst = 1'b1;
    send(12); send(12); send(12);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_phase got=%0b exp=0", out_valid); end
    send(16);
    checks++; if (dout !== 8'd13 || out_valid !== 1'b1) begin failures++; $display("FAIL arst_fresh got=%0d/%0b exp=13/1", dout, out_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    din = '0;
    sync_clr = 1'b0;
    out_ready = 1'b0;
    #12;
    test_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    test_average();
    test_rounding();
    test_saturate();
    test_overflow();
    test_back_to_back();
    test_sync_clr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_decim_out.md
# fir_decim_out

Output stage placed directly downstream of the first-order FIR: it consumes the FIR's 10-bit unsigned result stream and decimates it by `DECIM` using accumulate-and-dump averaging. It rounds and saturates each average to 8 bits and delivers it through a 2-entry ready/valid buffer to the capture or DMA logic. Sticky flags report saturation and dropped results.

## Interface
- `DECIM`, 4: decimation ratio; power of two, 2..16.
- `IN_W`, 10: input sample width, unsigned; matches the FIR output.
- `OUT_W`, 8: output sample width, unsigned.

- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset is asynchronous and active-low. Assertion immediately forces the reset state; deassertion is synchronous to `clk` (upstream requirement).
- `in_valid` in 1: `din` holds a new FIR sample this cycle.
- `din` in IN_W: FIR output sample.
- `sync_clr` in 1: synchronous restart. Clears accumulator, phase, buffer and flags.
- `out_valid` out 1: buffer head is valid.
- `out_ready` in 1: consumer accepts the head this cycle.
- `dout` out OUT_W: buffer head value.
- `sat` out 1: sticky; set when any result was clipped.
- `ovf` out 1: sticky; set when a result was dropped because the buffer was full.

## Operation
- Accumulator `acc` has width `IN_W + log2(DECIM)`. Phase counter `ph` counts 0..DECIM-1.
- Sample accepted = `in_valid && !sync_clr`.
- Accepted sample with `ph < DECIM-1`: `acc += din`, `ph += 1`.
- Accepted sample with `ph == DECIM-1` (dump):
  - `sum = acc + din`.
  - `avg = (sum + DECIM/2) >> log2(DECIM)`, round half up, computed at full width.
  - `res = (avg > 2^OUT_W-1) ? 2^OUT_W-1 : avg`. If clipped, set `sat`.
  - Push `res` into the buffer. `acc <= 0`, `ph <= 0`.
- Buffer: 2-entry FIFO, in-order.
  - `out_valid` = not empty; `dout` = head, or 0 when empty.
  - Pop = `out_valid && out_ready`.
- Push while full:
  - With a pop in the same cycle: the push succeeds and occupancy stays 2.
  - Without a pop: `res` is discarded, `ovf` is set, and buffer contents are unchanged.
- Push and pop in the same cycle when occupancy is 1: occupancy stays 1 and the new value becomes the head.
- `sync_clr` has priority over everything in the same cycle:
  - `acc`, `ph`, the buffer, `sat` and `ovf` all go to 0.
  - The concurrent `in_valid` sample is dropped; a concurrent pop is ignored.
- `sat` and `ovf` are cleared only by `rst` or `sync_clr`.
- `out_ready` high while empty has no effect. `in_valid` has no backpressure: the FIR cannot stall.

## Timing
- Reset values: `out_valid`=0, `dout`=0, `sat`=0, `ovf`=0; internally `acc`=0, `ph`=0, buffer empty.
- Latency: the result is pushed on the edge that accepts the DECIM-th sample, so `out_valid`/`dout` update on that same edge (1 cycle from `din` presented to `dout` visible).
- Throughput: one result per DECIM accepted samples. Gaps in `in_valid` stall `ph` without losing state.
- Reset mid-accumulation: the partial sum is lost and the next accepted sample starts at `ph`=0.
- Pop takes effect on the edge where `out_valid && out_ready`; the next head (or empty state) is visible after that edge.

## Structure
- Package `fir_pkg`:
  - constants `FIR_IN_W`=10, `FIR_OUT_W`=8;
  - localparam helper for `log2(DECIM)`;
  - typedef for the output sample.
- Sub-module `fir_out_fifo`: 2-entry synchronous FIFO with push, pop, full, empty and head. It uses the same `clk`/`rst` and a synchronous `clr` input.
- The top level holds the accumulator, phase counter, round/saturate datapath and flags.

## Test plan
- Reset, DECIM=4, `din`=100,101,102,103 on consecutive `in_valid` cycles → `dout`=102 (406+2=408, 408>>2=102), `out_valid` rises on the 4th accepted edge; `sat`=0.
- `din`=1023 ×4 → avg=1023, `dout`=255, `sat`=1 and stays set until `sync_clr`.
- `out_ready`=0, three full dumps → first two results held in order, third dropped, `ovf`=1; then `out_ready`=1 → two pops in order, then `out_valid`=0.
- Buffer full, dump coinciding with `out_ready`=1 → head popped, new result appended, `ovf` stays 0.
- Two samples accepted, then `sync_clr` together with `in_valid` → flags, buffer and phase cleared. The next 4 samples 8,8,8,8 → `dout`=8.
- Assert `rst` between clock edges mid-accumulation → `out_valid`, `dout`, `sat` and `ovf` go to 0 immediately. After release, the next 4 samples produce a fresh average.
